// File: rtl/maxpool_seq_ctrl.sv
// maxpool_seq_ctrl
// Sequencer for 2x2 / stride-2 max pooling over a D-channel HxW feature map.
// It walks channel, output row and output column. For each window it issues
// four reads to a synchronous-read input buffer and reduces them with a
// signed running max. It then writes the pooled word to the output buffer.
// Each output word takes 5 cycles.
//
// Ports:
//   clk      - clock
//   reset_n  - asynchronous active-low reset
//   start    - begin one full pooling pass (sampled only while idle)
//   busy     - pass in progress
//   done     - one-cycle pulse together with the final write
//   rd_en    - input buffer read strobe
//   rd_addr  - input word address d*H*W + r*W + c
//   rd_data  - input buffer data, valid one cycle after rd_en
//   wr_en    - output buffer write strobe
//   wr_addr  - output word address d*(H/2)*(W/2) + orow*(W/2) + ocol
//   wr_data  - pooled (signed) maximum
module maxpool_seq_ctrl #(
    parameter int DATA_BITS = 32,
    parameter int D         = 32,
    parameter int H         = 46,
    parameter int W         = 46,
    parameter int IN_AW     = 17,
    parameter int OUT_AW    = 15
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic                 rd_en,
    output logic [IN_AW-1:0]     rd_addr,
    input  logic [DATA_BITS-1:0] rd_data,
    output logic                 wr_en,
    output logic [OUT_AW-1:0]    wr_addr,
    output logic [DATA_BITS-1:0] wr_data
);

    localparam int OH = H / 2;
    localparam int OW = W / 2;
    localparam int DW = (D  > 1) ? $clog2(D)  : 1;
    localparam int RW = (OH > 1) ? $clog2(OH) : 1;
    localparam int CW = (OW > 1) ? $clog2(OW) : 1;

    localparam logic [DW-1:0] D_LAST = DW'(D - 1);
    localparam logic [RW-1:0] R_LAST = RW'(OH - 1);
    localparam logic [CW-1:0] C_LAST = CW'(OW - 1);

    // Window top-left address steps by 2 along a row pair. When the column
    // wraps, it jumps to the next row pair, which is +W+2 from the last
    // window. This holds across a channel boundary as well, because the
    // channels are stored contiguously.
    localparam logic [IN_AW-1:0] STEP_COL = IN_AW'(2);
    localparam logic [IN_AW-1:0] STEP_ROW = IN_AW'(W + 2);
    localparam logic [IN_AW-1:0] OFF_TR   = IN_AW'(1);
    localparam logic [IN_AW-1:0] OFF_BL   = IN_AW'(W);
    localparam logic [IN_AW-1:0] OFF_BR   = IN_AW'(W + 1);

    typedef enum logic [2:0] {
        IDLE,
        RD0,
        RD1,
        RD2,
        RD3,
        CMP,
        FIN
    } state_t;

    state_t                       state;
    logic [DW-1:0]                d_cnt;
    logic [RW-1:0]                orow;
    logic [CW-1:0]                ocol;
    logic [IN_AW-1:0]             base;
    logic [OUT_AW-1:0]            win_idx;
    logic signed [DATA_BITS-1:0]  acc;

    logic signed [DATA_BITS-1:0]  rd_s;
    logic signed [DATA_BITS-1:0]  max_val;
    logic                         col_wrap;
    logic                         row_wrap;
    logic                         last_win;
    logic [IN_AW-1:0]             next_base;

    assign rd_s      = $signed(rd_data);
    assign max_val   = (rd_s > acc) ? rd_s : acc;
    assign col_wrap  = (ocol == C_LAST);
    assign row_wrap  = (orow == R_LAST);
    assign last_win  = (d_cnt == D_LAST) && row_wrap && col_wrap;
    assign next_base = col_wrap ? (base + STEP_ROW) : (base + STEP_COL);

    // The read address is registered one state ahead, so it is valid in the
    // same cycle as rd_en. rd_data arrives one state later. Because of that,
    // the top-left word is loaded into acc when leaving RD1, and the
    // bottom-right word is folded in when leaving CMP.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            rd_en   <= 1'b0;
            rd_addr <= '0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            d_cnt   <= '0;
            orow    <= '0;
            ocol    <= '0;
            base    <= '0;
            win_idx <= '0;
            acc     <= '0;
        end else begin
            wr_en <= 1'b0;
            done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= RD0;
                        busy    <= 1'b1;
                        d_cnt   <= '0;
                        orow    <= '0;
                        ocol    <= '0;
                        base    <= '0;
                        win_idx <= '0;
                        rd_en   <= 1'b1;
                        rd_addr <= '0;
                    end
                end
                RD0: begin
                    state   <= RD1;
                    rd_addr <= base + OFF_TR;
                end
                RD1: begin
                    state   <= RD2;
                    rd_addr <= base + OFF_BL;
                    acc     <= rd_s;
                end
                RD2: begin
                    state   <= RD3;
                    rd_addr <= base + OFF_BR;
                    acc     <= max_val;
                end
                RD3: begin
                    state   <= CMP;
                    rd_en   <= 1'b0;
                    rd_addr <= '0;
                    acc     <= max_val;
                end
                CMP: begin
                    acc     <= max_val;
                    wr_en   <= 1'b1;
                    wr_data <= max_val;
                    wr_addr <= win_idx;
                    win_idx <= win_idx + OUT_AW'(1);
                    if (col_wrap) begin
                        ocol <= '0;
                        if (row_wrap) begin
                            orow  <= '0;
                            d_cnt <= (d_cnt == D_LAST) ? '0 : d_cnt + DW'(1);
                        end else begin
                            orow <= orow + RW'(1);
                        end
                    end else begin
                        ocol <= ocol + CW'(1);
                    end
                    if (last_win) begin
                        state <= FIN;
                        done  <= 1'b1;
                    end else begin
                        state   <= RD0;
                        rd_en   <= 1'b1;
                        rd_addr <= next_base;
                        base    <= next_base;
                    end
                end
                FIN: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    rd_en <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_maxpool_seq_ctrl.sv
// tb_maxpool_seq_ctrl
// Self-checking bench for maxpool_seq_ctrl with D=2, H=4, W=4.
// The bench holds a behavioural input buffer with a synchronous read. From
// plain window arithmetic it predicts the expected handshake, read
// addresses and pooled writes on every cycle of a pass. The passes use ramp,
// signed, max-position, start-while-busy, reset-mid-pass, back-to-back and
// random data.
module tb_maxpool_seq_ctrl;

    localparam int DB   = 32;
    localparam int TD   = 2;
    localparam int TH   = 4;
    localparam int TW   = 4;
    localparam int IAW  = 8;
    localparam int OAW  = 6;
    localparam int NW   = TD * TH * TW;
    localparam int N    = NW / 4;
    localparam int LAST = 5 * N + 1;

    logic           clk;
    logic           reset_n;
    logic           start;
    logic           busy;
    logic           done;
    logic           rd_en;
    logic [IAW-1:0] rd_addr;
    logic [DB-1:0]  rd_data;
    logic           wr_en;
    logic [OAW-1:0] wr_addr;
    logic [DB-1:0]  wr_data;

    logic [DB-1:0]  mem [0:NW-1];
    logic [DB-1:0]  cap [0:N-1];

    int checks;
    int failures;

    maxpool_seq_ctrl #(
        .DATA_BITS(DB),
        .D(TD),
        .H(TH),
        .W(TW),
        .IN_AW(IAW),
        .OUT_AW(OAW)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .start(start),
        .busy(busy),
        .done(done),
        .rd_en(rd_en),
        .rd_addr(rd_addr),
        .rd_data(rd_data),
        .wr_en(wr_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Input buffer with a synchronous read.
    always @(posedge clk) begin
        if (rd_en) begin
            if (int'(rd_addr) < NW) rd_data <= mem[rd_addr];
            else                    rd_data <= 'x;
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int window_base(input int k);
        int per;
        int dd;
        int rem;
        int r;
        int c;
        per = (TH / 2) * (TW / 2);
        dd  = k / per;
        rem = k % per;
        r   = rem / (TW / 2);
        c   = rem % (TW / 2);
        return dd * TH * TW + 2 * r * TW + 2 * c;
    endfunction

    function automatic int window_offset(input int pos);
        case (pos)
            0:       return 0;
            1:       return 1;
            2:       return TW;
            default: return TW + 1;
        endcase
    endfunction

    function automatic logic [DB-1:0] window_max(input int k);
        int b;
        int m;
        int v;
        b = window_base(k);
        m = int'(mem[b]);
        for (int p = 1; p < 4; p++) begin
            v = int'(mem[b + window_offset(p)]);
            if (v > m) m = v;
        end
        return DB'(m);
    endfunction

    task automatic fill_random();
        for (int i = 0; i < NW; i++) mem[i] = $urandom();
    endtask

    task automatic check_idle_outputs(input string tag);
        checkOutput({tag, "_busy"},    64'(busy),    64'd0);
        checkOutput({tag, "_done"},    64'(done),    64'd0);
        checkOutput({tag, "_rd_en"},   64'(rd_en),   64'd0);
        checkOutput({tag, "_wr_en"},   64'(wr_en),   64'd0);
        checkOutput({tag, "_rd_addr"}, 64'(rd_addr), 64'd0);
        checkOutput({tag, "_wr_addr"}, 64'(wr_addr), 64'd0);
        checkOutput({tag, "_wr_data"}, 64'(wr_data), 64'd0);
    endtask

    // Runs one full pass from an IDLE cycle, entered just after a negedge.
    // glitch_cycle > 0 pulses start during the pass. hold_start leaves start
    // high afterwards, so the next pass begins right after IDLE.
    task automatic applyStimulus(input int glitch_cycle, input bit hold_start);
        bit exp_rd;
        bit exp_wr;
        int k;
        int off;
        int j;
        start = 1'b1;
        @(posedge clk);
        #1;
        if (!hold_start) start = 1'b0;
        for (int c = 1; c <= LAST; c++) begin
            @(negedge clk);
            k      = (c - 1) / 5;
            off    = (c - 1) % 5;
            exp_rd = (c <= 5 * N) && (off < 4);
            exp_wr = (c >= 6) && (off == 0);
            checkOutput("busy",  64'(busy),  64'd1);
            checkOutput("done",  64'(done),  64'(c == LAST));
            checkOutput("rd_en", 64'(rd_en), 64'(exp_rd));
            checkOutput("wr_en", 64'(wr_en), 64'(exp_wr));
            if (exp_rd)
                checkOutput("rd_addr", 64'(rd_addr), 64'(window_base(k) + window_offset(off)));
            if (exp_wr) begin
                j = k - 1;
                cap[j] = wr_data;
                checkOutput("wr_addr", 64'(wr_addr), 64'(j));
                checkOutput("wr_data", 64'(wr_data), 64'(window_max(j)));
            end
            if (glitch_cycle > 0 && c == glitch_cycle) start = 1'b1;
            if (glitch_cycle > 0 && c == glitch_cycle + 1 && !hold_start) start = 1'b0;
        end
        @(negedge clk);
        checkOutput("post_busy",  64'(busy),  64'd0);
        checkOutput("post_done",  64'(done),  64'd0);
        checkOutput("post_wr_en", 64'(wr_en), 64'd0);
        checkOutput("post_rd_en", 64'(rd_en), 64'd0);
    endtask

    initial begin
        int b;
        checks   = 0;
        failures = 0;
        reset_n  = 1'b0;
        start    = 1'b0;
        rd_data  = '0;
        for (int i = 0; i < NW; i++) mem[i] = DB'(i);

        #2;
        check_idle_outputs("reset");
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        $display("[TB] ramp pass");
        applyStimulus(0, 1'b0);
        checkOutput("ramp_first", 64'(cap[0]), 64'd5);
        checkOutput("ramp_mid",   64'(cap[3]), 64'd15);
        checkOutput("ramp_last",  64'(cap[7]), 64'd31);

        $display("[TB] signed pass");
        fill_random();
        b = window_base(0);
        mem[b]          = 32'hFFFFFFFD;
        mem[b + 1]      = 32'hFFFFFFFF;
        mem[b + TW]     = 32'hFFFFFFF8;
        mem[b + TW + 1] = 32'hFFFFFFFE;
        b = window_base(1);
        mem[b]          = 32'hFFFFFFFB;
        mem[b + 1]      = 32'h00000004;
        mem[b + TW]     = 32'h80000000;
        mem[b + TW + 1] = 32'h00000003;
        applyStimulus(0, 1'b0);
        checkOutput("signed_neg", 64'(cap[0]), 64'h0000_0000_FFFF_FFFF);
        checkOutput("signed_mix", 64'(cap[1]), 64'd4);

        $display("[TB] max position pass");
        fill_random();
        for (int k = 0; k < 4; k++) begin
            b = window_base(k);
            for (int p = 0; p < 4; p++)
                mem[b + window_offset(p)] = DB'(-int'($urandom_range(0, 1000)));
            mem[b + window_offset(k)] = DB'(500 + k);
        end
        applyStimulus(0, 1'b0);
        for (int k = 0; k < 4; k++)
            checkOutput("maxpos", 64'(cap[k]), 64'(500 + k));

        $display("[TB] start while busy");
        fill_random();
        applyStimulus(10, 1'b0);

        $display("[TB] reset mid pass");
        fill_random();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (17) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check_idle_outputs("midreset");
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check_idle_outputs("after_reset");
        applyStimulus(0, 1'b0);

        $display("[TB] back to back");
        fill_random();
        applyStimulus(0, 1'b1);
        fill_random();
        applyStimulus(0, 1'b0);

        $display("[TB] random passes");
        for (int t = 0; t < 3; t++) begin
            fill_random();
            applyStimulus(0, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
